// File: rtl/vex_bus_pkg.sv
// Shared types for the iBus/dBus to AXI arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vex_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_XFER,
    WR_RESP
  } state_t;

  typedef enum logic {
    REQ_IBUS = 1'b0,
    REQ_DBUS = 1'b1
  } req_id_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/vex_addr_xlate.sv
// Address translation: pass addresses above the threshold through, rebase the rest.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module vex_addr_xlate
  import vex_bus_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] abs_address,
  input  logic [63:0] base,
  output logic [63:0] xaddr
);

  // Addresses equal to the threshold still take the base; the add wraps mod 2^64.
  always_comb begin
    if (addr > abs_address) begin
      xaddr = {32'd0, addr};
    end else begin
      xaddr = {32'd0, addr} + base;
    end
  end

endmodule

// File: rtl/vex_bus_arbiter.sv
// Round-robin share of one single-beat AXI master between iBus (read) and dBus.
// Latency: cmd accept to AXI valid 1 cycle; read response combinational on the R beat.
// Backpressure: one transaction in flight; cmd_ready pulses only on the IDLE grant cycle.
module vex_bus_arbiter
  import vex_bus_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic [31:0]                   abs_address,
  input  logic [63:0]                   ibus_base,
  input  logic [63:0]                   dbus_base,
  input  logic                          ibus_cmd_valid,
  output logic                          ibus_cmd_ready,
  input  logic [31:0]                   ibus_cmd_address,
  output logic                          ibus_rsp_valid,
  output logic [31:0]                   ibus_rsp_data,
  output logic                          ibus_rsp_error,
  input  logic                          dbus_cmd_valid,
  output logic                          dbus_cmd_ready,
  input  logic                          dbus_cmd_wr,
  input  logic [31:0]                   dbus_cmd_address,
  input  logic [31:0]                   dbus_cmd_data,
  input  logic [3:0]                    dbus_cmd_mask,
  output logic                          dbus_rsp_valid,
  output logic [31:0]                   dbus_rsp_data,
  output logic                          dbus_rsp_error,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wlast,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  output logic                          wr_err
);

  state_t      state;
  state_t      state_nxt;
  req_id_t     rr_pref;    // bus that wins when both request
  req_id_t     id_q;
  req_id_t     grant_id;
  logic        grant;
  logic        grant_wr;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;
  logic        wr_q;
  logic        aw_pend;
  logic        w_pend;
  logic        rd_beat;
  logic [63:0] base_sel;
  logic [63:0] xaddr;
  logic        unused_sig;

  // Grant is only possible in IDLE and never while reset is held.
  always_comb begin
    grant    = (state == IDLE) && !areset && (ibus_cmd_valid || dbus_cmd_valid);
    grant_id = REQ_IBUS;
    if (ibus_cmd_valid && dbus_cmd_valid) begin
      grant_id = rr_pref;
    end else if (dbus_cmd_valid) begin
      grant_id = REQ_DBUS;
    end
    grant_wr = (grant_id == REQ_DBUS) && dbus_cmd_wr;
  end

  assign ibus_cmd_ready = grant && (grant_id == REQ_IBUS);
  assign dbus_cmd_ready = grant && (grant_id == REQ_DBUS);

  // State register.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: WR_XFER leaves only once both AW and W have retired, possibly together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = grant_wr ? WR_XFER : RD_ADDR;
      RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
      RD_DATA: if (m_axi_rvalid) state_nxt = IDLE;
      WR_XFER: if ((!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready)) state_nxt = WR_RESP;
      WR_RESP: if (m_axi_bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded AXI handshakes and response steering.
  always_comb begin
    m_axi_arvalid  = (state == RD_ADDR);
    m_axi_awvalid  = (state == WR_XFER) && wr_q && aw_pend;
    m_axi_wvalid   = (state == WR_XFER) && wr_q && w_pend;
    m_axi_rready   = (state == RD_DATA);
    m_axi_bready   = (state == WR_RESP);
    rd_beat        = m_axi_rready && m_axi_rvalid;
    ibus_rsp_valid = rd_beat && (id_q == REQ_IBUS);
    dbus_rsp_valid = rd_beat && (id_q == REQ_DBUS);
  end

  // Capture the granted command and hand priority to the other bus.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rr_pref <= REQ_IBUS;
      id_q    <= REQ_IBUS;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
    end else if (grant) begin
      id_q    <= grant_id;
      rr_pref <= (grant_id == REQ_IBUS) ? REQ_DBUS : REQ_IBUS;
      wr_q    <= grant_wr;
      if (grant_id == REQ_IBUS) begin
        addr_q <= ibus_cmd_address;
        data_q <= '0;
        mask_q <= '0;
      end else begin
        addr_q <= dbus_cmd_address;
        data_q <= dbus_cmd_data;
        mask_q <= dbus_cmd_mask;
      end
    end
  end

  // Per-channel outstanding flags so AW and W retire independently.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (grant) begin
      aw_pend <= grant_wr;
      w_pend  <= grant_wr;
    end else begin
      if (m_axi_awvalid && m_axi_awready) aw_pend <= 1'b0;
      if (m_axi_wvalid && m_axi_wready)   w_pend  <= 1'b0;
    end
  end

  // Sticky write-error flag, cleared only by reset.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_err <= 1'b0;
    end else if (m_axi_bready && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) begin
      wr_err <= 1'b1;
    end
  end

  assign base_sel = (id_q == REQ_DBUS) ? dbus_base : ibus_base;

  vex_addr_xlate u_xlate (
    .addr        (addr_q),
    .abs_address (abs_address),
    .base        (base_sel),
    .xaddr       (xaddr)
  );

  assign m_axi_araddr   = xaddr[C_M_AXI_ADDR_WIDTH-1:0];
  assign m_axi_awaddr   = xaddr[C_M_AXI_ADDR_WIDTH-1:0];
  assign m_axi_arlen    = 8'd0;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wdata    = data_q;
  assign m_axi_wstrb    = mask_q;
  assign ibus_rsp_data  = m_axi_rdata;
  assign dbus_rsp_data  = m_axi_rdata;
  assign ibus_rsp_error = m_axi_rresp[1];
  assign dbus_rsp_error = m_axi_rresp[1];

  // Single-beat bursts make rlast redundant; rresp[0] carries no error meaning here.
  assign unused_sig = ^{m_axi_rlast, m_axi_rresp[0]};

endmodule

// File: tb/tb_vex_bus_arbiter.sv
// Directed testbench for vex_bus_arbiter.
// Latency: n/a.
// Backpressure: AXI slave side driven by hand per scenario.
module tb_vex_bus_arbiter;

  logic        ap_clk;
  logic        areset;
  logic [31:0] abs_address;
  logic [63:0] ibus_base, dbus_base;
  logic        ibus_cmd_valid, ibus_cmd_ready;
  logic [31:0] ibus_cmd_address;
  logic        ibus_rsp_valid, ibus_rsp_error;
  logic [31:0] ibus_rsp_data;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr;
  logic [31:0] dbus_cmd_address, dbus_cmd_data;
  logic [3:0]  dbus_cmd_mask;
  logic        dbus_rsp_valid, dbus_rsp_error;
  logic [31:0] dbus_rsp_data;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        wr_err;

  int n_cmp = 0;
  int n_err = 0;

  vex_bus_arbiter dut (
    .ap_clk(ap_clk), .areset(areset), .abs_address(abs_address),
    .ibus_base(ibus_base), .dbus_base(dbus_base),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_address(ibus_cmd_address),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_data(ibus_rsp_data), .ibus_rsp_error(ibus_rsp_error),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready), .dbus_cmd_wr(dbus_cmd_wr),
    .dbus_cmd_address(dbus_cmd_address), .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_mask(dbus_cmd_mask),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_error(dbus_rsp_error),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .wr_err(wr_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset;
    areset = 1'b1;
    tick;
    tick;
    areset = 1'b0;
  endtask

  // Entered right after the edge into RD_ADDR; leaves right after the edge back to IDLE.
  task automatic serve_read(input logic [31:0] d, input logic [1:0] r);
    m_axi_arready = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b1;
    m_axi_rdata   = d;
    m_axi_rresp   = r;
    tick;
    m_axi_rvalid  = 1'b0;
    m_axi_rresp   = 2'b00;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    ibus_cmd_valid = 1'b1;
    dbus_cmd_valid = 1'b1;
    tick;
    tick;
    #1;
    n_cmp++; if (ibus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ibus_ready: got %b want 0", ibus_cmd_ready); end
    n_cmp++; if (dbus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_dbus_ready: got %b want 0", dbus_cmd_ready); end
    n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", m_axi_arvalid); end
    n_cmp++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_aw_w_valid: got %b%b want 00", m_axi_awvalid, m_axi_wvalid); end
    n_cmp++; if (m_axi_rready !== 1'b0 || m_axi_bready !== 1'b0) begin n_err++; $display("FAIL rst_r_b_ready: got %b%b want 00", m_axi_rready, m_axi_bready); end
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL rst_wr_err: got %b want 0", wr_err); end
    n_cmp++; if (ibus_rsp_valid !== 1'b0 || dbus_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b%b want 00", ibus_rsp_valid, dbus_rsp_valid); end
    ibus_cmd_valid = 1'b0;
    dbus_cmd_valid = 1'b0;
    areset = 1'b0;
    tick;
  endtask

  task automatic test_ibus_read;
    abs_address = 32'h0000_8000;
    ibus_base   = 64'h1_0000_0000;
    ibus_cmd_valid = 1'b1;
    ibus_cmd_address = 32'h100;
    #1;
    n_cmp++; if (ibus_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rd_ibus_ready: got %b want 1", ibus_cmd_ready); end
    tick;
    ibus_cmd_valid = 1'b0;
    #1;
    n_cmp++; if (m_axi_arvalid !== 1'b1) begin n_err++; $display("FAIL rd_arvalid: got %b want 1", m_axi_arvalid); end
    n_cmp++; if (m_axi_araddr !== 64'h1_0000_0100) begin n_err++; $display("FAIL rd_araddr: got %h want %h", m_axi_araddr, 64'h1_0000_0100); end
    n_cmp++; if (m_axi_arlen !== 8'd0) begin n_err++; $display("FAIL rd_arlen: got %h want 0", m_axi_arlen); end
    n_cmp++; if (ibus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rd_ready_pulse: got %b want 0", ibus_cmd_ready); end
    m_axi_arready = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rdata = 32'hDEAD_BEEF;
    m_axi_rresp = 2'b00;
    #1;
    n_cmp++; if (m_axi_rready !== 1'b1 || m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL rd_rready: got rready=%b arvalid=%b want 1 0", m_axi_rready, m_axi_arvalid); end
    n_cmp++; if (ibus_rsp_valid !== 1'b1 || ibus_rsp_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_rsp: got v=%b d=%h want 1 deadbeef", ibus_rsp_valid, ibus_rsp_data); end
    n_cmp++; if (ibus_rsp_error !== 1'b0 || dbus_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_side: got err=%b dv=%b want 0 0", ibus_rsp_error, dbus_rsp_valid); end
    tick;
    m_axi_rvalid = 1'b0;
    #1;
    n_cmp++; if (ibus_rsp_valid !== 1'b0 || m_axi_rready !== 1'b0) begin n_err++; $display("FAIL rd_done: got v=%b rready=%b want 0 0", ibus_rsp_valid, m_axi_rready); end
  endtask

  task automatic test_round_robin;
    do_reset;
    abs_address = 32'h0000_8000;
    ibus_base = 64'h1_0000_0000;
    dbus_base = 64'h2000;
    ibus_cmd_valid = 1'b1; ibus_cmd_address = 32'h200;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_address = 32'h300;
    #1;
    n_cmp++; if (ibus_cmd_ready !== 1'b1 || dbus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rr_first: got i=%b d=%b want 1 0", ibus_cmd_ready, dbus_cmd_ready); end
    tick;
    ibus_cmd_valid = 1'b0;
    #1;
    n_cmp++; if (dbus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rr_wait_ready: got %b want 0", dbus_cmd_ready); end
    n_cmp++; if (m_axi_araddr !== 64'h1_0000_0200) begin n_err++; $display("FAIL rr_ibus_addr: got %h want %h", m_axi_araddr, 64'h1_0000_0200); end
    serve_read(32'h1111_1111, 2'b00);
    #1;
    n_cmp++; if (dbus_cmd_ready !== 1'b1 || ibus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rr_second: got i=%b d=%b want 0 1", ibus_cmd_ready, dbus_cmd_ready); end
    tick;
    dbus_cmd_valid = 1'b0;
    #1;
    n_cmp++; if (m_axi_araddr !== 64'h2300) begin n_err++; $display("FAIL rr_dbus_addr: got %h want %h", m_axi_araddr, 64'h2300); end
    m_axi_arready = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h2222_2222; m_axi_rresp = 2'b10;
    #1;
    n_cmp++; if (dbus_rsp_valid !== 1'b1 || dbus_rsp_error !== 1'b1 || ibus_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_dbus_rsp: got dv=%b de=%b iv=%b want 1 1 0", dbus_rsp_valid, dbus_rsp_error, ibus_rsp_valid); end
    tick;
    m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
    ibus_cmd_valid = 1'b1;
    dbus_cmd_valid = 1'b1;
    #1;
    n_cmp++; if (ibus_cmd_ready !== 1'b1 || dbus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rr_third: got i=%b d=%b want 1 0", ibus_cmd_ready, dbus_cmd_ready); end
    tick;
    ibus_cmd_valid = 1'b0;
    dbus_cmd_valid = 1'b0;
    serve_read(32'h3333_3333, 2'b00);
  endtask

  task automatic test_write;
    abs_address = 32'h0000_8000;
    dbus_base = 64'h2000;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b1; dbus_cmd_address = 32'h40;
    dbus_cmd_data = 32'hA5A5_A5A5; dbus_cmd_mask = 4'h3;
    #1;
    n_cmp++; if (dbus_cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b want 1", dbus_cmd_ready); end
    tick;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0;
    m_axi_wready = 1'b1; m_axi_awready = 1'b0;
    #1;
    n_cmp++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin n_err++; $display("FAIL wr_valids: got aw=%b w=%b want 1 1", m_axi_awvalid, m_axi_wvalid); end
    n_cmp++; if (m_axi_awaddr !== 64'h2040) begin n_err++; $display("FAIL wr_awaddr: got %h want %h", m_axi_awaddr, 64'h2040); end
    n_cmp++; if (m_axi_wdata !== 32'hA5A5_A5A5 || m_axi_wstrb !== 4'h3) begin n_err++; $display("FAIL wr_payload: got %h/%h want a5a5a5a5/3", m_axi_wdata, m_axi_wstrb); end
    n_cmp++; if (m_axi_wlast !== 1'b1 || m_axi_awlen !== 8'd0) begin n_err++; $display("FAIL wr_burst: got wlast=%b awlen=%h want 1 0", m_axi_wlast, m_axi_awlen); end
    tick;
    m_axi_wready = 1'b0;
    #1;
    n_cmp++; if (m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b1) begin n_err++; $display("FAIL wr_cycle2: got aw=%b w=%b want 1 0", m_axi_awvalid, m_axi_wvalid); end
    tick;
    m_axi_awready = 1'b1;
    #1;
    n_cmp++; if (m_axi_awvalid !== 1'b1 || m_axi_bready !== 1'b0) begin n_err++; $display("FAIL wr_cycle3: got aw=%b bready=%b want 1 0", m_axi_awvalid, m_axi_bready); end
    tick;
    m_axi_awready = 1'b0;
    #1;
    n_cmp++; if (m_axi_awvalid !== 1'b0 || m_axi_bready !== 1'b1) begin n_err++; $display("FAIL wr_resp_state: got aw=%b bready=%b want 0 1", m_axi_awvalid, m_axi_bready); end
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    #1;
    n_cmp++; if (dbus_rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_no_rsp: got %b want 0", dbus_rsp_valid); end
    tick;
    m_axi_bvalid = 1'b0;
    #1;
    n_cmp++; if (m_axi_bready !== 1'b0 || wr_err !== 1'b0) begin n_err++; $display("FAIL wr_done: got bready=%b wr_err=%b want 0 0", m_axi_bready, wr_err); end
  endtask

  task automatic test_wr_err;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b1; dbus_cmd_address = 32'h44;
    dbus_cmd_data = 32'h1; dbus_cmd_mask = 4'hF;
    tick;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    #1;
    n_cmp++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin n_err++; $display("FAIL err_valids: got aw=%b w=%b want 1 1", m_axi_awvalid, m_axi_wvalid); end
    tick;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    #1;
    n_cmp++; if (m_axi_bready !== 1'b1) begin n_err++; $display("FAIL err_same_cycle: got bready=%b want 1", m_axi_bready); end
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    tick;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    #1;
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", wr_err); end
    ibus_cmd_valid = 1'b1; ibus_cmd_address = 32'h10;
    tick;
    ibus_cmd_valid = 1'b0;
    serve_read(32'h0, 2'b00);
    #1;
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", wr_err); end
    do_reset;
    #1;
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", wr_err); end
  endtask

  task automatic test_addr_boundary;
    abs_address = 32'h0000_8000;
    ibus_base = 64'h1_0000_0000;
    ibus_cmd_valid = 1'b1; ibus_cmd_address = 32'h8000;
    tick;
    ibus_cmd_valid = 1'b0;
    #1;
    n_cmp++; if (m_axi_araddr !== 64'h1_0000_8000) begin n_err++; $display("FAIL xl_equal: got %h want %h", m_axi_araddr, 64'h1_0000_8000); end
    serve_read(32'h0, 2'b00);
    ibus_cmd_valid = 1'b1; ibus_cmd_address = 32'h8001;
    tick;
    ibus_cmd_valid = 1'b0;
    #1;
    n_cmp++; if (m_axi_araddr !== 64'h8001) begin n_err++; $display("FAIL xl_above: got %h want %h", m_axi_araddr, 64'h8001); end
    serve_read(32'h0, 2'b00);
    abs_address = 32'hFFFF_FFFF;
    dbus_base = 64'hFFFF_FFFF_0000_0001;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_address = 32'hFFFF_FFFF;
    tick;
    dbus_cmd_valid = 1'b0;
    #1;
    n_cmp++; if (m_axi_araddr !== 64'h0) begin n_err++; $display("FAIL xl_wrap: got %h want 0", m_axi_araddr); end
    serve_read(32'h0, 2'b00);
  endtask

  task automatic test_reset_mid;
    abs_address = 32'h0000_8000;
    ibus_cmd_valid = 1'b1; ibus_cmd_address = 32'h100;
    tick;
    ibus_cmd_valid = 1'b0;
    m_axi_arready = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    #1;
    n_cmp++; if (m_axi_rready !== 1'b1) begin n_err++; $display("FAIL mid_in_rdata: got rready=%b want 1", m_axi_rready); end
    areset = 1'b1;
    tick;
    areset = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678;
    #1;
    n_cmp++; if (m_axi_rready !== 1'b0 || m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL mid_idle: got rready=%b arvalid=%b want 0 0", m_axi_rready, m_axi_arvalid); end
    n_cmp++; if (ibus_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp: got %b want 0", ibus_rsp_valid); end
    m_axi_rvalid = 1'b0;
    ibus_cmd_valid = 1'b1;
    #1;
    n_cmp++; if (ibus_cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_regrant: got %b want 1", ibus_cmd_ready); end
    ibus_cmd_valid = 1'b0;
    tick;
  endtask

  task automatic test_drop_before_grant;
    ibus_cmd_valid = 1'b1; ibus_cmd_address = 32'h20;
    tick;
    ibus_cmd_valid = 1'b0;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b1;
    #1;
    n_cmp++; if (dbus_cmd_ready !== 1'b0) begin n_err++; $display("FAIL drop_busy_ready: got %b want 0", dbus_cmd_ready); end
    m_axi_arready = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0;
    m_axi_rvalid = 1'b1;
    tick;
    m_axi_rvalid = 1'b0;
    tick;
    #1;
    n_cmp++; if (m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin n_err++; $display("FAIL drop_no_txn: got aw=%b ar=%b w=%b want 0 0 0", m_axi_awvalid, m_axi_arvalid, m_axi_wvalid); end
    n_cmp++; if (wr_err !== 1'b0 || dbus_rsp_valid !== 1'b0) begin n_err++; $display("FAIL drop_no_err: got wr_err=%b dv=%b want 0 0", wr_err, dbus_rsp_valid); end
  endtask

  initial begin
    areset = 1'b1;
    abs_address = '0; ibus_base = '0; dbus_base = '0;
    ibus_cmd_valid = 1'b0; ibus_cmd_address = '0;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0; dbus_cmd_address = '0;
    dbus_cmd_data = '0; dbus_cmd_mask = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b1;
    test_reset;
    test_ibus_read;
    test_round_robin;
    test_write;
    test_wr_err;
    test_addr_boundary;
    test_reset_mid;
    test_drop_before_grant;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
